// File: rtl/uart_rx_ly9.sv
// uart_rx_ly9: 8N1 UART receiver with mid-bit sampling, framing-error detection and good-byte count.
// Optional build macro MAJORITY_VOTE_EN: 2-of-3 vote around each sample point, decisions one clock later.
module uart_rx_ly9 #(
    parameter int CLK_PER_BIT = 2500,
    parameter int CNT_W       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy,
    output logic [7:0] rx_count
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    localparam logic [CNT_W-1:0] TICK = CNT_W'(CLK_PER_BIT - 1);

    state_t           state;
    logic [1:0]       sync;
    logic             rx_s;
    logic             smp;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    assign rx_s    = sync[1];
    assign rx_busy = (state != IDLE);

`ifdef MAJORITY_VOTE_EN
    // Start check waits one extra clock so the vote window is centred on the mid-bit point
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_PER_BIT / 2);
    logic [1:0] hist;
    // Keep the two previous synchronised samples for the 2-of-3 vote
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hist <= 2'b11;
        else        hist <= {hist[0], rx_s};
    assign smp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
    assign smp = rx_s;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], line_rx};

    // Frame FSM with baud counter, shifter and registered result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_count  <= '0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= smp ? IDLE : DATA;
                    end else cnt <= cnt + 1'b1;
                end
                DATA: begin
                    if (cnt == TICK) begin
                        cnt   <= '0;
                        shift <= {smp, shift[7:1]};
                        idx   <= idx + 1'b1;
                        if (idx == 3'd7) state <= STOP;
                    end else cnt <= cnt + 1'b1;
                end
                STOP: begin
                    if (cnt == TICK) begin
                        cnt <= '0;
                        if (smp) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            rx_count <= rx_count + 8'd1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                BRK: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ly9.sv
// tb_uart_rx_ly9: directed vector table plus random frames against a byte-level receive model.
module tb_uart_rx_ly9;
    localparam int P = 16;
`ifdef MAJORITY_VOTE_EN
    localparam int MV = 1;
    localparam logic [7:0] G_EXP = 8'h00;
`else
    localparam int MV = 0;
    localparam logic [7:0] G_EXP = 8'h04;
`endif
    localparam int LAT = 2 + P / 2 + 9 * P + 1 + MV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_rx = 1'b1;
    logic [7:0] rx_data, rx_count;
    logic       rx_valid, frame_err, rx_busy;

    uart_rx_ly9 #(.CLK_PER_BIT(P), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .line_rx(line_rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int nvalid = 0, nerr = 0, nboth = 0;
    int cyc = 0, vcyc = 0, fall_cyc = 0;
    int m_count = 0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin
            nvalid++;
            vcyc = cyc;
        end
        if (frame_err) nerr++;
        if (rx_valid && frame_err) nboth++;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         glitch;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
        int         exp_count;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch);
        logic lvl;
        int b;
        fall_cyc = cyc;
        for (int c = 0; c < 10 * P; c++) begin
            b = c / P;
            lvl = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
            line_rx = (c == glitch) ? ~lvl : lvl;
            @(negedge clk);
        end
        if (!stop) begin
            line_rx = 1'b0;
            repeat (3 * P) @(negedge clk);
        end
    endtask

    task automatic frame_check(input string name, input logic [7:0] d, input logic stop, input int glitch,
                               input int exp_valid, input int exp_err, input logic [7:0] exp_data,
                               input int exp_count);
        int v0, e0;
        v0 = nvalid;
        e0 = nerr;
        send_frame(d, stop, glitch);
        line_rx = 1'b1;
        repeat (P / 2) @(negedge clk);
        chk({name, " busy_idle"}, rx_busy, 0);
        repeat (P / 2) @(negedge clk);
        chk({name, " valid_pulses"}, nvalid - v0, exp_valid);
        chk({name, " err_pulses"}, nerr - e0, exp_err);
        chk({name, " rx_data"}, rx_data, exp_data);
        chk({name, " rx_count"}, rx_count, exp_count);
        if (exp_valid == 1) chk({name, " latency"}, vcyc - fall_cyc, LAT);
    endtask

    initial begin
        int v0, e0, nv_abort, gap;
        logic [7:0] d;
        logic stop;
        vecs[0] = '{8'h4F, 1'b1, -1, 1, 0, 8'h4F, 1};
        vecs[1] = '{8'h31, 1'b1, -1, 1, 0, 8'h31, 2};
        vecs[2] = '{8'h4F, 1'b1, -1, 1, 0, 8'h4F, 3};
        vecs[3] = '{8'h30, 1'b1, -1, 1, 0, 8'h30, 4};
        vecs[4] = '{8'h55, 1'b0, -1, 0, 1, 8'h30, 4};
        vecs[5] = '{8'hA5, 1'b1, -1, 1, 0, 8'hA5, 5};
        vecs[6] = '{8'h00, 1'b1, 3 * P + P / 2, 1, 0, G_EXP, 6};

        repeat (3) @(negedge clk);
        chk("reset rx_data", rx_data, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset rx_busy", rx_busy, 0);
        chk("reset rx_count", rx_count, 0);
        rst_n = 1'b1;
        repeat (P) @(negedge clk);

        for (int i = 0; i < 7; i++)
            frame_check($sformatf("vec%0d", i), vecs[i].d, vecs[i].stop, vecs[i].glitch,
                        vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_count);
        m_count = 6;
        m_data = G_EXP;

        v0 = nvalid;
        e0 = nerr;
        line_rx = 1'b0;
        repeat (P / 2 - 4) @(negedge clk);
        line_rx = 1'b1;
        repeat (2 * P) @(negedge clk);
        chk("short_low valid", nvalid - v0, 0);
        chk("short_low err", nerr - e0, 0);
        chk("short_low busy", rx_busy, 0);
        chk("short_low rx_count", rx_count, m_count);

        nv_abort = nvalid;
        d = 8'h3C;
        for (int c = 0; c < 5 * P; c++) begin
            line_rx = (c < P) ? 1'b0 : d[c/P-1];
            @(negedge clk);
        end
        chk("midframe busy", rx_busy, 1);
        rst_n = 1'b0;
        line_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort rx_count", rx_count, 0);
        chk("abort rx_data", rx_data, 0);
        chk("abort busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (2 * P) @(negedge clk);
        m_count = 1;
        m_data = 8'h3C;
        frame_check("after_abort", 8'h3C, 1'b1, -1, 1, 0, m_data, m_count);
        chk("after_abort total_valid", nvalid - nv_abort, 1);

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 2);
            line_rx = 1'b1;
            repeat (gap * P) @(negedge clk);
            if (stop) begin
                m_count = (m_count + 1) % 256;
                m_data = d;
            end
            frame_check($sformatf("rand%0d", i), d, stop, -1, stop ? 1 : 0, stop ? 0 : 1, m_data, m_count);
        end

        chk("valid_and_err_same_cycle", nboth, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
